multi_tc: RTL and testbench
===========================

MULTI_TC -- requirements
Module: multi_tc

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent timer channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, counter/preset width (8..32); unused read bits return 0.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port addr  input  $clog2(NUM_CH)+2  word address: upper bits = channel, low 2 bits = register (0 CTRL, 1 PRESET, 2 COUNT, 3 STATUS).
REQ-006 SHALL have port we  input  1  write strobe for addressed register.
REQ-007 SHALL have port wdata  input  32  write data.
REQ-008 SHALL have port rdata  output  32  combinational read data of addressed register, zero latency.
REQ-009 SHALL have port irq  output  NUM_CH  per-channel level interrupt.
REQ-010 SHALL have port irq_any  output  1  OR of irq.

Function
REQ-011 CTRL SHALL be: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM, [7:4] PS prescale exponent; other bits read 0.
REQ-012 PRESET SHALL be read/write CNT_W bits; COUNT SHALL be read-only, writes ignored.
REQ-013 STATUS[0] SHALL be sticky PEND; writing 1 clears it, writing 0 has no effect; other bits read 0.
REQ-014 Each channel SHALL run FSM IDLE, LOAD, CNT, INT.
REQ-015 IDLE -> LOAD when EN=1; LOAD SHALL set COUNT=PRESET, clear prescaler, -> CNT.
REQ-016 In CNT a tick SHALL occur every 2^PS cycles; on tick: COUNT==0 -> INT with PEND set on that edge, else COUNT decrements by 1.
REQ-017 INT SHALL last one cycle: MODE one-shot -> IDLE and EN cleared; auto-reload -> LOAD.
REQ-018 EN cleared by software in LOAD/CNT SHALL -> IDLE next edge, COUNT held, PEND unchanged.
REQ-019 Latency (PS=0): EN written at edge 0 -> PEND set at edge P+3; auto-reload period P+3 cycles; with PS, CNT lasts (P+1)*2^PS cycles.
REQ-020 PRESET=0 SHALL expire at first tick in CNT, no wrap.
REQ-021 PRESET written during CNT SHALL take effect only at next LOAD.
REQ-022 irq[i] SHALL equal PEND[i] AND IM[i]; IM change affects irq same cycle, PEND unaffected.
REQ-023 Simultaneous W1C and expiry on one channel SHALL leave PEND=1 (set wins).
REQ-024 CTRL write on the expiry edge SHALL take the written value; one-shot EN clear applies only if no CTRL write that edge.
REQ-025 Channel index >= NUM_CH: writes ignored, rdata=0.

Reset
REQ-026 reset low SHALL immediately force all CTRL, PRESET, COUNT, PEND, prescalers to 0, FSMs to IDLE, irq and irq_any to 0.
REQ-027 Reset asserted mid-count SHALL abort with no PEND; after release channels stay IDLE until EN written.

Structure
REQ-028 Shared package multi_tc_pkg SHALL hold register offsets, CTRL bit positions, MODE encodings, FSM state typedef.
REQ-029 Per-channel logic SHALL be sub-module tc_channel, instantiated NUM_CH times by generate; multi_tc holds decode, read mux, irq_any.

Verification
REQ-030 PRESET=5, CTRL=0x9 (EN,IM,one-shot) at edge 0 -> irq[0]=1 after edge 8, EN reads 0, COUNT=0.
REQ-031 Ch1 PRESET=3, CTRL=0xB (auto-reload,IM) -> PEND every 6 cycles; W1C STATUS=1 drops irq[1] next cycle, re-asserts next period.
REQ-032 PRESET=2, CTRL=0x21 (PS=2,no IM) -> PEND after 1+1+12 cycles, irq stays 0, setting IM raises irq same cycle.
REQ-033 W1C on exact expiry edge -> PEND reads 1; reset pulsed low mid-CNT -> all reads 0, irq_any=0 asynchronously.
REQ-034 NUM_CH=4, CNT_W=16: write PRESET=0x12345 ch3 -> reads 0x2345; access ch4 address (if decodable) -> rdata 0, no state change.

Source files
------------

// File: rtl/multi_tc_pkg.sv
// Shared definitions for the multi-channel down-counting timer: register map,
// CTRL field layout, mode encodings and channel FSM states.
package multi_tc_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL bit layout: [7:4] PS, [3] IM, [2:1] MODE, [0] EN
    typedef struct packed {
        logic [3:0] ps;
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);
    localparam int unsigned PRE_W  = 15;

    // Only 01 reloads; every other MODE encoding behaves as one-shot
    localparam logic [1:0] MODE_AUTO = 2'b01;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_CNT  = 2'd2;
    localparam state_t ST_INT  = 2'd3;

    function automatic logic is_auto(input ctrl_t c);
        return c.mode == MODE_AUTO;
    endfunction

endpackage

// File: rtl/tc_channel.sv
// One timer channel: CTRL/PRESET/COUNT/PEND registers, prescaler and the
// IDLE/LOAD/CNT/INT sequencer.
module tc_channel
    import multi_tc_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ctrl_we,
    input  logic              preset_we,
    input  logic              status_we,
    input  logic [31:0]       wdata,
    output logic [CTRL_W-1:0] ctrl,
    output logic [CNT_W-1:0]  preset,
    output logic [CNT_W-1:0]  count,
    output logic              pend,
    output logic              irq_c
);

    state_t            state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  preset_q, preset_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [PRE_W-1:0]  ps_mask;
    logic              pend_q, pend_d;
    logic              tick;
    logic              expire;

    // Tick once every 2^PS counting cycles
    assign ps_mask = ~({PRE_W{1'b1}} << ctrl_q.ps);
    assign tick    = (pre_q & ps_mask) == ps_mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            pre_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pre_q    <= pre_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        pre_d    = pre_q;
        pend_d   = pend_q;
        expire   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q.en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else begin
                    count_d = preset_q;
                    pre_d   = '0;
                    state_d = ST_CNT;
                end
            end
            ST_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    pre_d = '0;
                    if (count_q == '0) begin
                        expire  = 1'b1;
                        state_d = ST_INT;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            ST_INT: begin
                state_d = is_auto(ctrl_q) ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A software CTRL write on the expiry edge overrides the one-shot EN clear
        if (ctrl_we) begin
            ctrl_d = ctrl_t'(wdata[CTRL_W-1:0]);
        end else if (expire && !is_auto(ctrl_q)) begin
            ctrl_d.en = 1'b0;
        end

        if (preset_we) preset_d = wdata[CNT_W-1:0];

        // Expiry beats a same-edge write-1-to-clear
        if (expire) begin
            pend_d = 1'b1;
        end else if (status_we && wdata[0]) begin
            pend_d = 1'b0;
        end
    end

    assign ctrl   = ctrl_q;
    assign preset = preset_q;
    assign count  = count_q;
    assign pend   = pend_q;
    assign irq_c  = pend_q & ctrl_q.im;

endmodule

// File: rtl/multi_tc.sv
// Multi-channel timer top: address decode, zero-latency read mux and
// interrupt aggregation around NUM_CH independent channels.
module multi_tc
    import multi_tc_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [$clog2(NUM_CH)+1:0] addr,
    input  logic                      we,
    input  logic [31:0]               wdata,
    output logic [31:0]               rdata,
    output logic [NUM_CH-1:0]         irq,
    output logic                      irq_any
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0]   ch;
    logic [1:0]        reg_sel;
    logic [CTRL_W-1:0] ctrl_a   [NUM_CH];
    logic [CNT_W-1:0]  preset_a [NUM_CH];
    logic [CNT_W-1:0]  count_a  [NUM_CH];
    logic [NUM_CH-1:0] pend_a;

    assign reg_sel = addr[1:0];

    // A single-channel build has no channel bits in the address
    generate
        if (NUM_CH > 1) begin : g_ch_dec
            assign ch = addr[$clog2(NUM_CH)+1:2];
        end else begin : g_ch_one
            assign ch = '0;
        end
    endgenerate

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        logic sel;
        assign sel = we && (ch == CH_W'(i));

        tc_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .ctrl_we  (sel && (reg_sel == REG_CTRL)),
            .preset_we(sel && (reg_sel == REG_PRESET)),
            .status_we(sel && (reg_sel == REG_STATUS)),
            .wdata    (wdata),
            .ctrl     (ctrl_a[i]),
            .preset   (preset_a[i]),
            .count    (count_a[i]),
            .pend     (pend_a[i]),
            .irq_c    (irq[i])
        );
    end

    // Channel indices with no instance fall through and read as zero
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch == CH_W'(i)) begin
                case (reg_sel)
                    REG_CTRL:   rdata = 32'(ctrl_a[i]);
                    REG_PRESET: rdata = 32'(preset_a[i]);
                    REG_COUNT:  rdata = 32'(count_a[i]);
                    REG_STATUS: rdata = {31'b0, pend_a[i]};
                    default:    rdata = '0;
                endcase
            end
        end
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_multi_tc.sv
// Directed bench for multi_tc: register-access table plus hand-timed
// sequences for latency, auto-reload, prescale, W1C races and reset.
module tb_multi_tc;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  irq;
    logic        irq_any;

    logic [3:0]  addr_b;
    logic        we_b;
    logic [31:0] wdata_b;
    logic [31:0] rdata_b;
    logic [2:0]  irq_b;
    logic        irq_any_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk = ~clk;

    multi_tc #(.NUM_CH(2), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata),
        .rdata(rdata), .irq(irq), .irq_any(irq_any)
    );

    multi_tc #(.NUM_CH(3), .CNT_W(16)) u_dut_b (
        .clk(clk), .reset(reset), .addr(addr_b), .we(we_b), .wdata(wdata_b),
        .rdata(rdata_b), .irq(irq_b), .irq_any(irq_any_b)
    );

    typedef struct {
        logic        dev;
        logic        wr;
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick(1);
        we = 1'b0;
    endtask

    task automatic wr_b(input logic [3:0] a, input logic [31:0] d);
        addr_b = a; wdata_b = d; we_b = 1'b1;
        tick(1);
        we_b = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(name, rdata, exp);
    endtask

    task automatic rd_chk_b(input string name, input logic [3:0] a, input logic [31:0] exp);
        addr_b = a;
        #1;
        chk(name, rdata_b, exp);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick(1);
    endtask

    initial begin
        reset = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        we_b = 1'b0; addr_b = '0; wdata_b = '0;
        #1;
        for (int i = 0; i < 8; i++) rd_chk($sformatf("rst_rd%0d", i), 3'(i), 32'h0);
        chk("rst_irq_any", 32'(irq_any), 32'h0);
        chk("rst_irq_any_b", 32'(irq_any_b), 32'h0);
        #2;
        reset = 1'b1;
        tick(1);

        // Register access table; dev 1 is the NUM_CH=3, CNT_W=16 instance
        vecs.push_back('{1'b0, 1'b1, 4'h0, 32'hFFFF_FFF6, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 4'h0, 32'h0,         32'h0000_00F6});
        vecs.push_back('{1'b0, 1'b1, 4'h1, 32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 4'h1, 32'h0,         32'hDEAD_BEEF});
        vecs.push_back('{1'b0, 1'b1, 4'h2, 32'h0000_1234, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 4'h2, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 1'b1, 4'h3, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 4'h3, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 1'b0, 4'h4, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 1'b1, 4'h5, 32'h0000_0003, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 4'h5, 32'h0,         32'h0000_0003});
        vecs.push_back('{1'b0, 1'b0, 4'h1, 32'h0,         32'hDEAD_BEEF});
        vecs.push_back('{1'b0, 1'b1, 4'h0, 32'h0,         32'h0});
        vecs.push_back('{1'b0, 1'b0, 4'h0, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 1'b1, 4'h9, 32'h0001_2345, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 4'h9, 32'h0,         32'h0000_2345});
        vecs.push_back('{1'b1, 1'b1, 4'hC, 32'h0000_00FF, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 4'hD, 32'h0000_AAAA, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 4'hC, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 1'b0, 4'hD, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 1'b0, 4'hF, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 1'b0, 4'h0, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 1'b0, 4'h4, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 1'b0, 4'h8, 32'h0,         32'h0});
        vecs.push_back('{1'b1, 1'b0, 4'h9, 32'h0,         32'h0000_2345});
        vecs.push_back('{1'b1, 1'b1, 4'hA, 32'h0000_FFFF, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 4'hA, 32'h0,         32'h0});

        foreach (vecs[i]) begin
            if (!vecs[i].dev) begin
                if (vecs[i].wr) wr(3'(vecs[i].a), vecs[i].d);
                else rd_chk($sformatf("vec%0d", i), 3'(vecs[i].a), vecs[i].exp);
            end else begin
                if (vecs[i].wr) wr_b(vecs[i].a, vecs[i].d);
                else rd_chk_b($sformatf("vec%0d", i), vecs[i].a, vecs[i].exp);
            end
        end
        chk("b_irq_any_idle", 32'(irq_any_b), 32'h0);

        // One-shot, PRESET=5: expiry on edge 8 after the CTRL write
        do_reset();
        wr(3'd1, 32'd5);
        wr(3'd0, 32'h9);
        tick(7);
        chk("os_irq_e7", 32'(irq[0]), 32'h0);
        rd_chk("os_cnt_e7", 3'd2, 32'h0);
        tick(1);
        chk("os_irq_e8", 32'(irq[0]), 32'h1);
        chk("os_any_e8", 32'(irq_any), 32'h1);
        rd_chk("os_ctrl_e8", 3'd0, 32'h8);
        rd_chk("os_cnt_e8", 3'd2, 32'h0);
        tick(4);
        rd_chk("os_cnt_idle", 3'd2, 32'h0);
        rd_chk("os_stat_idle", 3'd3, 32'h1);
        wr(3'd3, 32'h1);
        chk("os_irq_w1c", 32'(irq[0]), 32'h0);

        // Auto-reload on ch1, PRESET=3: PEND every 6 cycles
        do_reset();
        wr(3'd5, 32'd3);
        wr(3'd4, 32'hB);
        tick(5);
        chk("ar_irq_e5", 32'(irq[1]), 32'h0);
        tick(1);
        chk("ar_irq_e6", 32'(irq[1]), 32'h1);
        rd_chk("ar_stat_e6", 3'd7, 32'h1);
        wr(3'd7, 32'h1);
        chk("ar_irq_w1c", 32'(irq[1]), 32'h0);
        tick(2);
        rd_chk("ar_cnt_e9", 3'd6, 32'h2);
        tick(2);
        chk("ar_irq_e11", 32'(irq[1]), 32'h0);
        tick(1);
        chk("ar_irq_e12", 32'(irq[1]), 32'h1);
        chk("ar_any_e12", 32'(irq_any), 32'h1);
        chk("ar_irq0", 32'(irq[0]), 32'h0);

        // Prescale PS=2, PRESET=2, IM off: expiry on edge 14
        do_reset();
        wr(3'd1, 32'd2);
        wr(3'd0, 32'h21);
        tick(13);
        rd_chk("ps_stat_e13", 3'd3, 32'h0);
        rd_chk("ps_cnt_e13", 3'd2, 32'h0);
        tick(1);
        rd_chk("ps_stat_e14", 3'd3, 32'h1);
        chk("ps_irq_noim", 32'(irq[0]), 32'h0);
        wr(3'd0, 32'h28);
        chk("ps_irq_im", 32'(irq[0]), 32'h1);
        rd_chk("ps_stat_im", 3'd3, 32'h1);

        // W1C landing on the expiry edge: set wins
        do_reset();
        wr(3'd1, 32'd0);
        wr(3'd0, 32'h9);
        tick(2);
        wr(3'd3, 32'h1);
        rd_chk("race_stat", 3'd3, 32'h1);
        chk("race_irq", 32'(irq[0]), 32'h1);
        wr(3'd3, 32'h1);
        rd_chk("race_w1c_after", 3'd3, 32'h0);

        // CTRL write on the expiry edge keeps EN; next expiry clears it
        do_reset();
        wr(3'd0, 32'h9);
        tick(2);
        wr(3'd0, 32'h9);
        rd_chk("ctlx_ctrl_e3", 3'd0, 32'h9);
        tick(3);
        rd_chk("ctlx_ctrl_e6", 3'd0, 32'h9);
        tick(1);
        rd_chk("ctlx_ctrl_e7", 3'd0, 32'h8);

        // Asynchronous reset in the middle of counting
        do_reset();
        wr(3'd1, 32'd100);
        wr(3'd0, 32'hB);
        wr(3'd5, 32'd0);
        wr(3'd4, 32'hB);
        tick(4);
        chk("mid_any_pre", 32'(irq_any), 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_any_async", 32'(irq_any), 32'h0);
        chk("mid_irq_async", 32'(irq), 32'h0);
        for (int i = 0; i < 8; i++) rd_chk($sformatf("mid_rd%0d", i), 3'(i), 32'h0);
        reset = 1'b1;
        tick(10);
        rd_chk("post_ctrl", 3'd0, 32'h0);
        rd_chk("post_cnt", 3'd2, 32'h0);
        rd_chk("post_stat", 3'd3, 32'h0);
        chk("post_any", 32'(irq_any), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
